// File: rtl/npu_cmd_sched.sv
// npu_cmd_sched
// Queues matrix-multiply / convolution requests from the CPU and launches
// them one at a time on the NPU, reporting completion, timeouts and
// dropped requests back to the CPU.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   cpu_start_matrix_mul  one-cycle request: enqueue a matmul op
//   cpu_start_conv        one-cycle request: enqueue a conv op
//   cpu_cfg[63:0]         descriptor captured with the request
//   cmd_ready             queue can accept a request this cycle
//   npu_start             one-cycle launch strobe to the NPU
//   npu_op[1:0]           01 matmul, 10 conv, 00 when nothing launched
//   npu_cfg[63:0]         descriptor of the launched command
//   npu_done              completion pulse from the NPU
//   cpu_done              one-cycle completion pulse to the CPU
//   cpu_err               sticky timeout flag
//   cpu_ovf               sticky dropped-request flag
//   err_clr               clears cpu_err and cpu_ovf
//   busy                  FSM active or queue non-empty
//   q_count               current queue occupancy
module npu_cmd_sched #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cpu_start_matrix_mul,
    input  logic                     cpu_start_conv,
    input  logic [63:0]              cpu_cfg,
    output logic                     cmd_ready,
    output logic                     npu_start,
    output logic [1:0]               npu_op,
    output logic [63:0]              npu_cfg,
    input  logic                     npu_done,
    output logic                     cpu_done,
    output logic                     cpu_err,
    output logic                     cpu_ovf,
    input  logic                     err_clr,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT);

    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] WAIT_ONE  = 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] OP_MATMUL = 2'b01;
    localparam logic [1:0] OP_CONV   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_COMPLETE,
        S_ERROR
    } state_t;

    state_t          state, next_state;
    logic [1:0]      mem_op  [DEPTH];
    logic [63:0]     mem_cfg [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   wait_cnt;
    logic [1:0]      cur_op;
    logic [63:0]     cur_cfg;

    logic            req, push, pop, ovf_event, timeout_hit;
    logic [1:0]      push_op;

    // Matmul takes priority when both starts arrive together; the conv half
    // of such a request is counted as a dropped request.
    assign req       = cpu_start_matrix_mul | cpu_start_conv;
    assign push_op   = cpu_start_matrix_mul ? OP_MATMUL : OP_CONV;
    assign cmd_ready = (q_count < CNT_FULL) | pop;
    assign push      = rst_n & req & cmd_ready;
    assign ovf_event = (req & ~cmd_ready) | (cpu_start_matrix_mul & cpu_start_conv);
    assign busy      = (state != S_IDLE) | (q_count != '0);

    // Queue storage needs no reset: occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_op[wr_ptr]  <= push_op;
            mem_cfg[wr_ptr] <= cpu_cfg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            q_count  <= '0;
            wait_cnt <= '0;
            cur_op   <= '0;
            cur_cfg  <= '0;
            cpu_err  <= 1'b0;
            cpu_ovf  <= 1'b0;
        end else begin
            state <= next_state;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   q_count <= q_count + CNT_ONE;
                2'b01:   q_count <= q_count - CNT_ONE;
                default: q_count <= q_count;
            endcase
            // Counter is zero on the first WAIT cycle, so the timeout fires
            // on the TIMEOUT-th WAIT cycle.
            wait_cnt <= (state == S_WAIT) ? wait_cnt + WAIT_ONE : '0;
            // Launched command is latched so npu_op/npu_cfg stay stable
            // through WAIT even if the queue slot is overwritten.
            if (pop) begin
                cur_op  <= mem_op[rd_ptr];
                cur_cfg <= mem_cfg[rd_ptr];
            end
            // A new event in the same cycle as err_clr keeps the flag set.
            cpu_err <= timeout_hit | (cpu_err & ~err_clr);
            cpu_ovf <= ovf_event   | (cpu_ovf & ~err_clr);
        end
    end

    always_comb begin
        next_state  = state;
        npu_start   = 1'b0;
        npu_op      = 2'b00;
        npu_cfg     = '0;
        cpu_done    = 1'b0;
        pop         = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (q_count != '0) next_state = S_ISSUE;
            end
            S_ISSUE: begin
                pop        = 1'b1;
                npu_start  = 1'b1;
                npu_op     = mem_op[rd_ptr];
                npu_cfg    = mem_cfg[rd_ptr];
                next_state = S_WAIT;
            end
            S_WAIT: begin
                npu_op  = cur_op;
                npu_cfg = cur_cfg;
                if (npu_done) begin
                    next_state = S_COMPLETE;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout_hit = 1'b1;
                    next_state  = S_ERROR;
                end
            end
            S_COMPLETE: begin
                cpu_done   = 1'b1;
                next_state = S_IDLE;
            end
            S_ERROR: begin
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_npu_cmd_sched.sv
// tb_npu_cmd_sched
// Directed testbench for npu_cmd_sched (DEPTH=4, TIMEOUT=16). Each task
// drives one scenario and checks hand-computed expectations inline.
module tb_npu_cmd_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_start_matrix_mul, cpu_start_conv;
    logic [63:0] cpu_cfg;
    logic        cmd_ready, npu_start;
    logic [1:0]  npu_op;
    logic [63:0] npu_cfg;
    logic        npu_done, cpu_done, cpu_err, cpu_ovf, err_clr, busy;
    logic [2:0]  q_count;

    int tests_run    = 0;
    int tests_failed = 0;
    int start_seen   = 0;
    int done_seen    = 0;

    always #5 clk = ~clk;

    npu_cmd_sched #(.DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_start_matrix_mul(cpu_start_matrix_mul), .cpu_start_conv(cpu_start_conv),
        .cpu_cfg(cpu_cfg), .cmd_ready(cmd_ready), .npu_start(npu_start),
        .npu_op(npu_op), .npu_cfg(npu_cfg), .npu_done(npu_done),
        .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_ovf(cpu_ovf),
        .err_clr(err_clr), .busy(busy), .q_count(q_count)
    );

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (npu_start) start_seen++;
        if (cpu_done)  done_seen++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cpu_start_matrix_mul = 1'b1; cpu_start_conv = 1'b0;
        cpu_cfg = 64'hDEAD; npu_done = 1'b0; err_clr = 1'b0;
        step(); step();
        tests_run++; if (npu_start !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_npu_start: got %b expected 0", npu_start); end
        tests_run++; if (npu_op !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_npu_op: got %b expected 00", npu_op); end
        tests_run++; if (npu_cfg !== 64'h0) begin tests_failed++; $display("[TB] FAIL reset_npu_cfg: got %h expected 0", npu_cfg); end
        tests_run++; if (cpu_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_cpu_done: got %b expected 0", cpu_done); end
        tests_run++; if (cpu_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_cpu_err: got %b expected 0", cpu_err); end
        tests_run++; if (cpu_ovf !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_cpu_ovf: got %b expected 0", cpu_ovf); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        tests_run++; if (q_count !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_q_count: got %0d expected 0", q_count); end
        tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        cpu_start_matrix_mul = 1'b0; cpu_cfg = '0; rst_n = 1'b1;
        step();
        tests_run++; if (q_count !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_req_ignored: got %0d expected 0", q_count); end
    endtask

    task automatic test_single_matmul();
        int s0, d0;
        s0 = start_seen; d0 = done_seen;
        cpu_start_matrix_mul = 1'b1; cpu_cfg = 64'h1000;
        step();
        cpu_start_matrix_mul = 1'b0; cpu_cfg = '0;
        tests_run++; if (q_count !== 3'd1) begin tests_failed++; $display("[TB] FAIL single_q_count: got %0d expected 1", q_count); end
        tests_run++; if (npu_start !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_no_early_start: got %b expected 0", npu_start); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_busy: got %b expected 1", busy); end
        step();
        tests_run++; if (npu_start !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_start: got %b expected 1", npu_start); end
        tests_run++; if (npu_op !== 2'b01) begin tests_failed++; $display("[TB] FAIL single_op: got %b expected 01", npu_op); end
        tests_run++; if (npu_cfg !== 64'h1000) begin tests_failed++; $display("[TB] FAIL single_cfg: got %h expected 1000", npu_cfg); end
        step();
        tests_run++; if (npu_start !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_start_one_cycle: got %b expected 0", npu_start); end
        tests_run++; if (npu_cfg !== 64'h1000) begin tests_failed++; $display("[TB] FAIL single_cfg_held: got %h expected 1000", npu_cfg); end
        repeat (4) step();
        npu_done = 1'b1;
        tests_run++; if (cpu_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_done_early: got %b expected 0", cpu_done); end
        step();
        npu_done = 1'b0;
        tests_run++; if (cpu_done !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_cpu_done: got %b expected 1", cpu_done); end
        step();
        tests_run++; if (cpu_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_done_one_cycle: got %b expected 0", cpu_done); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_idle: got %b expected 0", busy); end
        tests_run++; if (start_seen - s0 !== 1) begin tests_failed++; $display("[TB] FAIL single_start_count: got %0d expected 1", start_seen - s0); end
        tests_run++; if (done_seen - d0 !== 1) begin tests_failed++; $display("[TB] FAIL single_done_count: got %0d expected 1", done_seen - d0); end
    endtask

    task automatic test_both_starts();
        int s0;
        s0 = start_seen;
        cpu_start_matrix_mul = 1'b1; cpu_start_conv = 1'b1; cpu_cfg = 64'h2A;
        step();
        cpu_start_matrix_mul = 1'b0; cpu_start_conv = 1'b0; cpu_cfg = '0;
        tests_run++; if (q_count !== 3'd1) begin tests_failed++; $display("[TB] FAIL both_q_count: got %0d expected 1", q_count); end
        tests_run++; if (cpu_ovf !== 1'b1) begin tests_failed++; $display("[TB] FAIL both_ovf: got %b expected 1", cpu_ovf); end
        step();
        tests_run++; if (npu_op !== 2'b01) begin tests_failed++; $display("[TB] FAIL both_op: got %b expected 01", npu_op); end
        tests_run++; if (npu_cfg !== 64'h2A) begin tests_failed++; $display("[TB] FAIL both_cfg: got %h expected 2a", npu_cfg); end
        step();
        npu_done = 1'b1;
        step();
        npu_done = 1'b0;
        step();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL both_idle: got %b expected 0", busy); end
        tests_run++; if (start_seen - s0 !== 1) begin tests_failed++; $display("[TB] FAIL both_single_launch: got %0d expected 1", start_seen - s0); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        tests_run++; if (cpu_ovf !== 1'b0) begin tests_failed++; $display("[TB] FAIL both_ovf_clear: got %b expected 0", cpu_ovf); end
    endtask

    task automatic test_back_to_back();
        int s0, n;
        logic [1:0] exp_op;
        s0 = start_seen;
        // Occupy the NPU first so the five requests see no pops.
        cpu_start_matrix_mul = 1'b1; cpu_cfg = 64'hA0;
        step();
        cpu_start_matrix_mul = 1'b0;
        step(); step();
        for (int i = 0; i < 5; i++) begin
            cpu_start_matrix_mul = (i % 2 == 0);
            cpu_start_conv       = (i % 2 != 0);
            cpu_cfg              = 64'h100 + 64'(i);
            if (i == 4) begin
                tests_run++; if (cmd_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_ready_full: got %b expected 0", cmd_ready); end
            end
            step();
        end
        cpu_start_matrix_mul = 1'b0; cpu_start_conv = 1'b0;
        tests_run++; if (q_count !== 3'd4) begin tests_failed++; $display("[TB] FAIL b2b_q_count: got %0d expected 4", q_count); end
        tests_run++; if (cpu_ovf !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_ovf: got %b expected 1", cpu_ovf); end
        err_clr = 1'b1; cpu_start_matrix_mul = 1'b1; cpu_cfg = 64'h1FF;
        step();
        cpu_start_matrix_mul = 1'b0; err_clr = 1'b0;
        tests_run++; if (cpu_ovf !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_ovf_clr_vs_event: got %b expected 1", cpu_ovf); end
        tests_run++; if (q_count !== 3'd4) begin tests_failed++; $display("[TB] FAIL b2b_q_unchanged: got %0d expected 4", q_count); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        tests_run++; if (cpu_ovf !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_ovf_clear: got %b expected 0", cpu_ovf); end
        npu_done = 1'b1;
        step();
        npu_done = 1'b0;
        tests_run++; if (cpu_done !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_first_done: got %b expected 1", cpu_done); end
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (npu_start !== 1'b1 && n < 10) begin
                step();
                n++;
            end
            exp_op = (k % 2 == 0) ? 2'b01 : 2'b10;
            tests_run++; if (npu_start !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_launch%0d_timeout: got %b expected 1", k, npu_start); end
            tests_run++; if (npu_op !== exp_op) begin tests_failed++; $display("[TB] FAIL b2b_launch%0d_op: got %b expected %b", k, npu_op, exp_op); end
            tests_run++; if (npu_cfg !== 64'h100 + 64'(k)) begin tests_failed++; $display("[TB] FAIL b2b_launch%0d_cfg: got %h expected %h", k, npu_cfg, 64'h100 + 64'(k)); end
            step();
            npu_done = 1'b1;
            step();
            npu_done = 1'b0;
        end
        step();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_idle: got %b expected 0", busy); end
        tests_run++; if (start_seen - s0 !== 5) begin tests_failed++; $display("[TB] FAIL b2b_launch_count: got %0d expected 5", start_seen - s0); end
    endtask

    task automatic test_timeout();
        int d0;
        cpu_start_matrix_mul = 1'b1; cpu_cfg = 64'h300;
        step();
        cpu_cfg = 64'h301;
        step();
        cpu_start_matrix_mul = 1'b0; cpu_cfg = '0;
        d0 = done_seen;
        tests_run++; if (npu_start !== 1'b1 || npu_cfg !== 64'h300) begin tests_failed++; $display("[TB] FAIL to_first_launch: got start=%b cfg=%h expected start=1 cfg=300", npu_start, npu_cfg); end
        repeat (16) step();
        tests_run++; if (cpu_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_err_early: got %b expected 0", cpu_err); end
        tests_run++; if (npu_cfg !== 64'h300) begin tests_failed++; $display("[TB] FAIL to_cfg_held: got %h expected 300", npu_cfg); end
        step();
        tests_run++; if (cpu_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL to_err_set: got %b expected 1", cpu_err); end
        tests_run++; if (cpu_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_no_done: got %b expected 0", cpu_done); end
        step(); step();
        tests_run++; if (npu_start !== 1'b1 || npu_cfg !== 64'h301) begin tests_failed++; $display("[TB] FAIL to_second_launch: got start=%b cfg=%h expected start=1 cfg=301", npu_start, npu_cfg); end
        tests_run++; if (done_seen - d0 !== 0) begin tests_failed++; $display("[TB] FAIL to_done_count: got %0d expected 0", done_seen - d0); end
        step();
        npu_done = 1'b1;
        step();
        npu_done = 1'b0;
        tests_run++; if (cpu_done !== 1'b1) begin tests_failed++; $display("[TB] FAIL to_second_done: got %b expected 1", cpu_done); end
        tests_run++; if (cpu_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL to_err_sticky: got %b expected 1", cpu_err); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        tests_run++; if (cpu_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_err_clear: got %b expected 0", cpu_err); end
    endtask

    task automatic test_done_on_timeout();
        cpu_start_matrix_mul = 1'b1; cpu_cfg = 64'h400;
        step();
        cpu_start_matrix_mul = 1'b0; cpu_cfg = '0;
        step();
        tests_run++; if (npu_start !== 1'b1) begin tests_failed++; $display("[TB] FAIL edge_launch: got %b expected 1", npu_start); end
        repeat (16) step();
        npu_done = 1'b1;
        step();
        npu_done = 1'b0;
        tests_run++; if (cpu_done !== 1'b1) begin tests_failed++; $display("[TB] FAIL edge_done_wins: got %b expected 1", cpu_done); end
        tests_run++; if (cpu_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL edge_no_err: got %b expected 0", cpu_err); end
        step();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL edge_idle: got %b expected 0", busy); end
    endtask

    task automatic test_reset_in_wait();
        int s0, d0;
        cpu_start_matrix_mul = 1'b1; cpu_start_conv = 1'b1; cpu_cfg = 64'h500;
        step();
        cpu_start_conv = 1'b0; cpu_cfg = 64'h501;
        step();
        cpu_cfg = 64'h502;
        step();
        cpu_start_matrix_mul = 1'b0; cpu_cfg = '0;
        tests_run++; if (q_count !== 3'd2) begin tests_failed++; $display("[TB] FAIL rstw_q_before: got %0d expected 2", q_count); end
        tests_run++; if (npu_cfg !== 64'h500) begin tests_failed++; $display("[TB] FAIL rstw_in_wait: got %h expected 500", npu_cfg); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        s0 = start_seen; d0 = done_seen;
        tests_run++; if ({npu_start, npu_op, cpu_done, cpu_err, cpu_ovf, busy} !== 7'b0) begin tests_failed++; $display("[TB] FAIL rstw_outputs: got start=%b op=%b done=%b err=%b ovf=%b busy=%b expected all 0", npu_start, npu_op, cpu_done, cpu_err, cpu_ovf, busy); end
        tests_run++; if (npu_cfg !== 64'h0) begin tests_failed++; $display("[TB] FAIL rstw_cfg: got %h expected 0", npu_cfg); end
        tests_run++; if (q_count !== 3'd0) begin tests_failed++; $display("[TB] FAIL rstw_q_flushed: got %0d expected 0", q_count); end
        npu_done = 1'b1;
        step();
        npu_done = 1'b0;
        step(); step();
        tests_run++; if (done_seen - d0 !== 0) begin tests_failed++; $display("[TB] FAIL rstw_stray_done: got %0d expected 0", done_seen - d0); end
        tests_run++; if (start_seen - s0 !== 0) begin tests_failed++; $display("[TB] FAIL rstw_no_launch: got %0d expected 0", start_seen - s0); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstw_idle: got %b expected 0", busy); end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_matmul();
        test_both_starts();
        test_back_to_back();
        test_timeout();
        test_done_on_timeout();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
